// File: rtl/sr_tx_scheduler.sv
// Round-robin scheduler sharing one 8-bit serial shift register between NUM_REQ byte producers.
// Define SR_TX_SCHEDULER_LATCH_EN to add a LATCH state that pulses o_latch after each shifted byte.
module sr_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_load,
  output logic [7:0]           o_data,
  input  logic                 i_sr_busy,
  output logic                 o_latch,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  // Handshake: a requester holds i_req high with stable data until its one-cycle o_ack
  // pulse; the byte is handed to the serializer with o_load, and the next grant only
  // happens after i_sr_busy has fallen.
`ifdef SR_TX_SCHEDULER_LATCH_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    LATCH  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3
  } state_t;
`endif

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  logic [7:0]      win_data;

  assign o_state = state;

  // Search starts just after the last winner and wraps, so nobody starves.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    win_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + 1 + i) % NUM_REQ);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      if (win_id == ID_W'(n)) win_data = i_data[8*n +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      o_ack      <= '0;
      o_load     <= 1'b0;
      o_latch    <= 1'b0;
      o_busy     <= 1'b0;
      o_data     <= 8'h00;
      o_grant_id <= '0;
    end else begin
      o_ack   <= '0;
      o_load  <= 1'b0;
      o_latch <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            o_data     <= win_data;
            o_grant_id <= win_id;
            ptr        <= win_id;
            o_ack      <= NUM_REQ'(1) << win_id;
            o_load     <= 1'b1;
            o_busy     <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD:   state <= SETTLE;
        // Guard cycle: the serializer may raise busy one cycle after the load strobe.
        SETTLE: state <= WAIT;
        WAIT: begin
          if (!i_sr_busy) begin
`ifdef SR_TX_SCHEDULER_LATCH_EN
            o_latch <= 1'b1;
            state   <= LATCH;
`else
            o_busy  <= 1'b0;
            state   <= IDLE;
`endif
          end
        end
`ifdef SR_TX_SCHEDULER_LATCH_EN
        LATCH: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_tx_scheduler.sv
// Bench for sr_tx_scheduler: behavioural serializer with programmable busy time and an expected-grant queue.
module tb_sr_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 8;
`ifdef SR_TX_SCHEDULER_LATCH_EN
  localparam int LATCH_EN = 1;
`else
  localparam int LATCH_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data = 32'h0;
  logic        sr_busy = 1'b0;
  logic [3:0]  o_ack;
  logic [1:0]  o_grant_id;
  logic        o_load;
  logic [7:0]  o_data;
  logic        o_latch;
  logic        o_busy;
  logic [2:0]  o_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_len = 14;
  int busy_cnt = 0;
  logic [W-1:0] exp_q[$];
  int load_t[$];

  sr_tx_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_ack(o_ack), .o_grant_id(o_grant_id), .o_load(o_load), .o_data(o_data),
    .i_sr_busy(sr_busy), .o_latch(o_latch), .o_busy(o_busy), .o_state(o_state)
  );

  // ---- clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---- serializer model: busy high for busy_len cycles starting the cycle after o_load
  always @(posedge clk) begin
    #2;
    if (rst) busy_cnt = 0;
    else if (o_load) busy_cnt = busy_len + 1;
    else if (busy_cnt > 0) busy_cnt--;
    sr_busy = (busy_cnt > 0) && !o_load;
  end

  // ---- scoreboard: every load strobe pops one expected {id, byte}
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && o_load) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_load: got id=%0d data=%02h, expected no load", o_grant_id, o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e[7:0] || o_grant_id !== e[W-1:8] || o_ack !== (4'b0001 << e[W-1:8])) begin
          bad++;
          $display("FAIL sb_load: got id=%0d data=%02h ack=%b, expected id=%0d data=%02h", o_grant_id, o_data, o_ack, e[W-1:8], e[7:0]);
        end
      end
    end
  end

  // ---- driver tasks
  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_loads(input int n, input bit clr);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 200) begin
      @(negedge clk);
      t++;
      if (o_load) begin
        seen++;
        load_t.push_back(cyc);
        if (clr) req = req & ~o_ack;
      end
    end
    total++;
    if (seen != n) begin
      bad++;
      $display("FAIL load_timeout: got %0d loads, expected %0d", seen, n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((o_busy || sr_busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: got o_busy=%b, expected 0", o_busy);
    end
  endtask

  // Called at the negedge of a load cycle; follows busy and checks the exit timing.
  task automatic check_exit(output int hi);
    int t = 0;
    bit err = 0;
    while (!sr_busy && t < 4) begin
      @(negedge clk);
      t++;
    end
    hi = 0;
    while (sr_busy && hi < 200) begin
      hi++;
      if (o_busy !== 1'b1 || o_load !== 1'b0 || o_latch !== 1'b0) err = 1;
      @(negedge clk);
    end
    total++;
    if (err || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_window: got err=%0d o_busy=%b, expected busy held, no load/latch", err, o_busy);
    end
    @(negedge clk);
    total++;
    if (LATCH_EN == 1) begin
      if (o_latch !== 1'b1 || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL exit_latch: got latch=%b busy=%b, expected latch=1 busy=1", o_latch, o_busy);
      end
      @(negedge clk);
      total++;
    end
    if (o_busy !== 1'b0 || o_latch !== 1'b0) begin
      bad++;
      $display("FAIL exit_idle: got busy=%b latch=%b, expected 0 0", o_busy, o_latch);
    end
  endtask

  // ---- tests
  task automatic test_reset();
    do_reset();
    total++;
    if (o_ack !== 4'b0 || o_load !== 1'b0 || o_latch !== 1'b0 || o_busy !== 1'b0 ||
        o_data !== 8'h00 || o_grant_id !== 2'd0 || o_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got ack=%b load=%b latch=%b busy=%b data=%02h id=%0d st=%0d, expected all 0",
               o_ack, o_load, o_latch, o_busy, o_data, o_grant_id, o_state);
    end
  endtask

  task automatic test_single();
    int hi;
    busy_len = 14;
    data[7:0] = 8'hA5;
    exp_q.push_back({2'd0, 8'hA5});
    req = 4'b0001;
    @(negedge clk);
    total++;
    if (o_load !== 1'b1 || o_ack !== 4'b0001 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: got load=%b ack=%b busy=%b, expected 1 0001 1", o_load, o_ack, o_busy);
    end
    req = 4'b0000;
    check_exit(hi);
    total++;
    if (hi != 14) begin
      bad++;
      $display("FAIL single_busy_len: got %0d, expected 14", hi);
    end
  endtask

  task automatic test_rr();
    do_reset();
    busy_len = 14;
    load_t.delete();
    data = 32'h43322110;
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd3, 8'h43});
    exp_q.push_back({2'd0, 8'h10});
    req = 4'b1111;
    run_loads(5, 1'b0);
    req = 4'b0000;
    for (int i = 1; i < load_t.size(); i++) begin
      total++;
      if (load_t[i] - load_t[i-1] != 17 + LATCH_EN) begin
        bad++;
        $display("FAIL rr_spacing: gap %0d got %0d, expected %0d", i, load_t[i] - load_t[i-1], 17 + LATCH_EN);
      end
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    busy_len = 6;
    data = 32'h44332211;
    exp_q.push_back({2'd2, 8'h33});
    req = 4'b0100;
    run_loads(1, 1'b1);
    exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h22});
    req = 4'b0011;
    run_loads(2, 1'b1);
    wait_idle();
  endtask

  task automatic test_long_busy();
    int hi;
    busy_len = 40;
    data = 32'hC3C2C1C0;
    exp_q.push_back({2'd3, 8'hC3});
    req = 4'b1000;
    run_loads(1, 1'b1);
    exp_q.push_back({2'd0, 8'hC0});
    req = 4'b0001;
    check_exit(hi);
    total++;
    if (hi != 40) begin
      bad++;
      $display("FAIL long_busy_len: got %0d, expected 40", hi);
    end
    busy_len = 5;
    run_loads(1, 1'b1);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    busy_len = 14;
    data = 32'hD3D2D1D0;
    exp_q.push_back({2'd1, 8'hD1});
    req = 4'b0010;
    run_loads(1, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (o_ack !== 4'b0 || o_load !== 1'b0 || o_latch !== 1'b0 || o_busy !== 1'b0 ||
        o_data !== 8'h00 || o_grant_id !== 2'd0 || o_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: got ack=%b load=%b latch=%b busy=%b data=%02h id=%0d st=%0d, expected all 0",
               o_ack, o_load, o_latch, o_busy, o_data, o_grant_id, o_state);
    end
    exp_q.push_back({2'd0, 8'hD0});
    exp_q.push_back({2'd3, 8'hD3});
    req = 4'b1001;
    run_loads(2, 1'b1);
    wait_idle();
  endtask

  task automatic test_latch();
    int pulses = 0;
    int latch_cyc = -1;
    int fall_cyc = -1;
    bit seen_busy = 0;
    busy_len = 14;
    data[7:0] = 8'hFF;
    exp_q.push_back({2'd0, 8'hFF});
    req = 4'b0001;
    run_loads(1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sr_busy) seen_busy = 1;
      if (seen_busy && !sr_busy && fall_cyc < 0) fall_cyc = cyc;
      if (o_latch) begin
        pulses++;
        latch_cyc = cyc;
      end
    end
    total++;
    if (pulses != LATCH_EN) begin
      bad++;
      $display("FAIL latch_count: got %0d, expected %0d", pulses, LATCH_EN);
    end
    if (LATCH_EN == 1) begin
      total++;
      if (latch_cyc != fall_cyc + 1) begin
        bad++;
        $display("FAIL latch_pos: got cycle %0d, expected %0d", latch_cyc, fall_cyc + 1);
      end
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL latch_idle: got o_busy=%b, expected 0", o_busy);
    end
  endtask

  // ---- sequence and final report
  initial begin
    test_reset();
    test_single();
    test_rr();
    test_wrap();
    test_long_busy();
    test_reset_mid();
    test_latch();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
